// File: rtl/stopwatch_ctrl.sv
// Run/pause/idle control for the mm:ss counter: debounced start/stop and clear buttons,
// a registered run level, a one-cycle clear pulse and a gated 1 Hz tick enable.
//
//   state | meaning
//   ------+-----------------------------------------------
//   00    | IDLE  - stopped and zeroed, prescaler held at 0
//   01    | RUN   - counting, prescaler advancing
//   10    | PAUSE - stopped, partial second preserved
//   11    | unused, recovers to IDLE on the next edge
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_DIV        = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_clr,
    output logic       run,
    output logic       paused,
    output logic       clr,
    output logic       tick,
    output logic [1:0] state
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int PS_W = $clog2(TICK_DIV);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    // bit 0 = start/stop, bit 1 = clear
    logic [1:0] btn_raw;
    logic [1:0] sync_q1;
    logic [1:0] sync_q2;
    logic [1:0] stable;
    logic [1:0] stable_d;
    logic [1:0] press;
    logic       press_ss;
    logic       press_clr;

    logic [1:0]      state_q;
    logic [1:0]      state_nx;
    logic            run_nx;
    logic            paused_nx;
    logic            clr_nx;
    logic [PS_W-1:0] presc;

    assign btn_raw = {btn_clr, btn_ss};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1  <= '0;
            sync_q2  <= '0;
            stable_d <= '0;
        end else begin
            sync_q1  <= btn_raw;
            sync_q2  <= sync_q1;
            stable_d <= stable;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_db
        logic [DB_W-1:0] cnt;
        logic            lvl;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync_q2[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == DB_MAX) begin
                lvl <= ~lvl;
                cnt <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end

        assign stable[i] = lvl;
    end

    // Rising edge of the debounced level only; releases are ignored.
    assign press     = stable & ~stable_d;
    assign press_ss  = press[0];
    assign press_clr = press[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            run     <= 1'b0;
            paused  <= 1'b0;
            clr     <= 1'b0;
        end else begin
            state_q <= state_nx;
            run     <= run_nx;
            paused  <= paused_nx;
            clr     <= clr_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        if (press_clr) begin
            state_nx = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (press_ss) state_nx = ST_RUN;
                ST_RUN:   if (press_ss) state_nx = ST_PAUSE;
                ST_PAUSE: if (press_ss) state_nx = ST_RUN;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        run_nx    = (state_nx == ST_RUN);
        paused_nx = (state_nx == ST_PAUSE);
        clr_nx    = press_clr;
    end

    // Only cycles that stay in RUN advance the second; the edge leaving RUN does not count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (state_nx == ST_IDLE) begin
                presc <= '0;
            end else if (state_q == ST_RUN && state_nx == ST_RUN) begin
                if (presc == PS_MAX) begin
                    presc <= '0;
                    tick  <= 1'b1;
                end else begin
                    presc <= presc + PS_W'(1);
                end
            end
        end
    end

    assign state = state_q;

endmodule
